// File: rtl/delay_eye_scan.sv
// Multi-channel IDELAY eye scan: sweeps each link's taps, counts P/N mismatches per
// point, finds the widest error-free window and loads its centre into both delay lines.
module delay_eye_scan #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TAP_W       = 9,
  parameter int unsigned STEP        = 8,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned DWELL_W     = 10,
  parameter int unsigned ERR_THRESH  = 0,
  parameter int unsigned DEFAULT_TAP = 0
) (
  input  logic                    clk160,
  input  logic                    rstb,
  input  logic                    start,
  input  logic [TAP_W-1:0]        err_offset,
  input  logic [8*N_CH-1:0]       d_p,
  input  logic [8*N_CH-1:0]       d_n,
  input  logic [N_CH-1:0]         d_valid,
  output logic [TAP_W*N_CH-1:0]   delay_set_p,
  output logic [TAP_W*N_CH-1:0]   delay_set_n,
  output logic [N_CH-1:0]         delay_wr_p,
  output logic [N_CH-1:0]         delay_wr_n,
  output logic [TAP_W*N_CH-1:0]   eye_width,
  output logic [N_CH-1:0]         lock_fail,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TAP_W:0]   STEP_X    = (TAP_W+1)'(STEP);
  localparam logic [TAP_W:0]   ONE_X     = (TAP_W+1)'(1);
  localparam logic [TAP_W:0]   TAP_MAX_1 = (TAP_W+1)'((2**TAP_W) - 1);
  localparam logic [TAP_W+1:0] TAP_MAX_2 = (TAP_W+2)'((2**TAP_W) - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [SET_W-1:0] LAST_SET  = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSettle, StDwell, StEval, StCenter, StNext, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q;
  logic [TAP_W:0]     t_q;
  logic [SET_W-1:0]   set_cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [15:0]        err_q;
  logic [TAP_W:0]     run_len_q, run_start_q, best_len_q, best_start_q;
  logic [7:0]         samp_p_q, samp_n_q;
  logic               samp_v_q;

  logic [TAP_W:0]     next_t, run_len_upd, run_start_upd, width_x;
  logic [TAP_W+1:0]   next_t_off;
  logic               sweep_end, point_good, err_now, dwell_last;
  logic [TAP_W-1:0]   centre;

  assign err_now       = samp_v_q && (samp_p_q != ~samp_n_q);
  assign dwell_last    = samp_v_q && (dwell_q == '1);
  assign next_t        = t_q + STEP_X;
  assign next_t_off    = {1'b0, next_t} + {2'b00, err_offset};
  // Stop once either the P tap or the offset N tap would leave the delay range.
  assign sweep_end     = ({1'b0, next_t} > TAP_MAX_2) || (next_t_off > TAP_MAX_2);
  assign point_good    = err_q <= 16'(ERR_THRESH);
  assign run_len_upd   = point_good ? run_len_q + ONE_X : '0;
  assign run_start_upd = (point_good && (run_len_q == '0)) ? t_q : run_start_q;
  assign width_x       = best_len_q * STEP_X;
  assign centre        = TAP_W'(best_start_q + (((best_len_q - ONE_X) * STEP_X) >> 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   state_d = StSettle;
      StSettle: if (set_cnt_q == LAST_SET) state_d = StDwell;
      StDwell:  if (dwell_last) state_d = StEval;
      StEval:   state_d = sweep_end ? StCenter : StLoad;
      StCenter: state_d = StNext;
      StNext:   state_d = (ch_q == LAST_CH) ? StDone : StLoad;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      ch_q         <= '0;
      t_q          <= '0;
      set_cnt_q    <= '0;
      dwell_q      <= '0;
      err_q        <= '0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      samp_p_q     <= '0;
      samp_n_q     <= '0;
      samp_v_q     <= 1'b0;
      delay_set_p  <= '0;
      delay_set_n  <= '0;
      delay_wr_p   <= '0;
      delay_wr_n   <= '0;
      eye_width    <= '0;
      lock_fail    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      delay_wr_p <= '0;
      delay_wr_n <= '0;
      done       <= 1'b0;
      samp_p_q   <= d_p[8*ch_q +: 8];
      samp_n_q   <= d_n[8*ch_q +: 8];
      samp_v_q   <= d_valid[ch_q];
      case (state_q)
        StIdle: begin
          if (start) begin
            ch_q         <= '0;
            t_q          <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            eye_width    <= '0;
            lock_fail    <= '0;
            busy         <= 1'b1;
          end
        end
        StLoad: begin
          delay_set_p[TAP_W*ch_q +: TAP_W] <= t_q[TAP_W-1:0];
          delay_set_n[TAP_W*ch_q +: TAP_W] <= TAP_W'(t_q + {1'b0, err_offset});
          delay_wr_p[ch_q] <= 1'b1;
          delay_wr_n[ch_q] <= 1'b1;
          set_cnt_q <= '0;
          dwell_q   <= '0;
          err_q     <= '0;
        end
        StSettle: set_cnt_q <= set_cnt_q + SET_W'(1);
        StDwell: begin
          if (samp_v_q) dwell_q <= dwell_q + DWELL_W'(1);
          if (err_now && (err_q != 16'hffff)) err_q <= err_q + 16'd1;
        end
        StEval: begin
          run_len_q   <= run_len_upd;
          run_start_q <= run_start_upd;
          // Strict compare keeps the first of equally wide windows.
          if (run_len_upd > best_len_q) begin
            best_len_q   <= run_len_upd;
            best_start_q <= run_start_upd;
          end
          t_q <= next_t;
        end
        StCenter: begin
          if (best_len_q != '0) begin
            delay_set_p[TAP_W*ch_q +: TAP_W] <= centre;
            delay_set_n[TAP_W*ch_q +: TAP_W] <= centre;
            eye_width[TAP_W*ch_q +: TAP_W]   <= (width_x > TAP_MAX_1) ? '1 : width_x[TAP_W-1:0];
            lock_fail[ch_q] <= 1'b0;
          end else begin
            delay_set_p[TAP_W*ch_q +: TAP_W] <= TAP_W'(DEFAULT_TAP);
            delay_set_n[TAP_W*ch_q +: TAP_W] <= TAP_W'(DEFAULT_TAP);
            eye_width[TAP_W*ch_q +: TAP_W]   <= '0;
            lock_fail[ch_q] <= 1'b1;
          end
          delay_wr_p[ch_q] <= 1'b1;
          delay_wr_n[ch_q] <= 1'b1;
        end
        StNext: begin
          ch_q         <= ch_q + CH_W'(1);
          t_q          <= '0;
          run_len_q    <= '0;
          run_start_q  <= '0;
          best_len_q   <= '0;
          best_start_q <= '0;
        end
        StDone: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_eye_scan.sv
// Bench for delay_eye_scan: an eye model drives P/N words from the loaded taps and
// whole scans are checked against windows computed from the sweep rules.
module tb_delay_eye_scan;

  localparam int unsigned N_CH        = 4;
  localparam int unsigned TAP_W       = 9;
  localparam int unsigned STEP        = 8;
  localparam int unsigned SETTLE_CYC  = 4;
  localparam int unsigned DWELL_W     = 5;
  localparam int unsigned ERR_THRESH  = 0;
  localparam int unsigned DEFAULT_TAP = 37;
  localparam int GAP     = 20;
  localparam int TAP_MAX = (1 << TAP_W) - 1;

  logic                  clk160 = 1'b0;
  logic                  rstb = 1'b0;
  logic                  start = 1'b0;
  logic [TAP_W-1:0]      err_offset = '0;
  logic [8*N_CH-1:0]     d_p = '0;
  logic [8*N_CH-1:0]     d_n = '0;
  logic [N_CH-1:0]       d_valid = '0;
  logic [TAP_W*N_CH-1:0] delay_set_p, delay_set_n, eye_width;
  logic [N_CH-1:0]       delay_wr_p, delay_wr_n, lock_fail;
  logic                  busy, done;

  delay_eye_scan #(
    .N_CH(N_CH), .TAP_W(TAP_W), .STEP(STEP), .SETTLE_CYC(SETTLE_CYC),
    .DWELL_W(DWELL_W), .ERR_THRESH(ERR_THRESH), .DEFAULT_TAP(DEFAULT_TAP)
  ) dut (
    .clk160(clk160), .rstb(rstb), .start(start), .err_offset(err_offset),
    .d_p(d_p), .d_n(d_n), .d_valid(d_valid),
    .delay_set_p(delay_set_p), .delay_set_n(delay_set_n),
    .delay_wr_p(delay_wr_p), .delay_wr_n(delay_wr_n),
    .eye_width(eye_width), .lock_fail(lock_fail), .busy(busy), .done(done)
  );

  always #5 clk160 = ~clk160;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mode = 0;
  bit gap_en = 1'b0;
  bit mon_en = 1'b0;
  int npts = 0;
  int exp_centre [N_CH];
  int exp_width [N_CH];
  int exp_lock [N_CH];
  int strobe_cnt [N_CH];
  int last_strobe [N_CH];
  int scan_ch = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int mk, mp, mn, mep, men, mt;
  bit mv;
  logic [7:0] wp;

  always @(posedge clk160) cyc++;

  task automatic check(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Eye pattern per mode: 1 = words at this tap arrive intact.
  function automatic bit good(input int m, input int c, input int t);
    if (m == 1) begin
      case (c)
        0:       return (t <= 63) || (t >= 256 && t <= 319);
        1:       return (t >= 96) && (t <= 223);
        2:       return 1'b0;
        default: return 1'b1;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic build_exp();
    int pts[$];
    int i, j, best_len, best_start;
    pts.delete();
    for (int t = 0; (t <= TAP_MAX) && (t + int'(err_offset) <= TAP_MAX); t += STEP)
      pts.push_back(t);
    npts = pts.size();
    for (int c = 0; c < N_CH; c++) begin
      best_len = 0;
      best_start = 0;
      i = 0;
      while (i < npts) begin
        if (!good(mode, c, pts[i])) i++;
        else begin
          j = i;
          while (j < npts && good(mode, c, pts[j])) j++;
          if (j - i > best_len) begin
            best_len = j - i;
            best_start = pts[i];
          end
          i = j;
        end
      end
      if (best_len > 0) begin
        exp_centre[c] = best_start + ((best_len - 1) * STEP) / 2;
        exp_width[c]  = (best_len * STEP > TAP_MAX) ? TAP_MAX : best_len * STEP;
        exp_lock[c]   = 0;
      end else begin
        exp_centre[c] = DEFAULT_TAP;
        exp_width[c]  = 0;
        exp_lock[c]   = 1;
      end
    end
  endtask

  function automatic int strobe_total();
    int s = 0;
    for (int c = 0; c < N_CH; c++) s += strobe_cnt[c];
    return s;
  endfunction

  // Monitor outputs, then present the next words from the currently loaded taps.
  always @(negedge clk160) begin
    if (rstb && mon_en) begin
      if (delay_wr_p != '0 || delay_wr_n != '0) begin
        check("wr_p_eq_wr_n", delay_wr_p, delay_wr_n);
        check("wr_onehot", longint'($onehot0(delay_wr_p)), 1);
      end
      for (int c = 0; c < N_CH; c++) begin
        if (delay_wr_p[c]) begin
          mk = strobe_cnt[c];
          mp = int'(delay_set_p[c*TAP_W +: TAP_W]);
          mn = int'(delay_set_n[c*TAP_W +: TAP_W]);
          if (mk < npts) begin
            mep = mk * STEP;
            men = mep + int'(err_offset);
          end else begin
            mep = exp_centre[c];
            men = exp_centre[c];
          end
          check($sformatf("ch%0d_strobe%0d_set_p", c, mk), mp, mep);
          check($sformatf("ch%0d_strobe%0d_set_n", c, mk), mn, men);
          if (mk == 0 && c == 0) check("start_to_strobe", cyc - start_cyc, 2);
          if (mk > 0)
            check($sformatf("ch%0d_strobe%0d_interval", c, mk), cyc - last_strobe[c],
                  2 + SETTLE_CYC + (1 << DWELL_W) + (gap_en ? GAP : 0));
          strobe_cnt[c]++;
          last_strobe[c] = cyc;
          scan_ch = c;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_center", cyc - last_strobe[N_CH-1], 2);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      mt = int'(delay_set_p[c*TAP_W +: TAP_W]);
      mv = 1'b1;
      if (gap_en && c == scan_ch && (cyc - last_strobe[c] >= SETTLE_CYC + 5) &&
          (cyc - last_strobe[c] < SETTLE_CYC + 5 + GAP)) mv = 1'b0;
      wp = 8'($urandom);
      d_p[c*8 +: 8] = wp;
      if (!mv) d_n[c*8 +: 8] = 8'($urandom);
      else if (good(mode, c, mt)) d_n[c*8 +: 8] = ~wp;
      else d_n[c*8 +: 8] = ~wp ^ (8'd1 << $urandom_range(0, 7));
      d_valid[c] = mv;
    end
  end

  task automatic prep(input int m, input int off, input bit gap);
    mode = m;
    err_offset = TAP_W'(off);
    gap_en = gap;
    build_exp();
    for (int c = 0; c < N_CH; c++) begin
      strobe_cnt[c] = 0;
      last_strobe[c] = -100000;
    end
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk160);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk160);
    start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_set_p"}, delay_set_p, 0);
    check({tag, "_set_n"}, delay_set_n, 0);
    check({tag, "_wr"}, {delay_wr_p, delay_wr_n}, 0);
    check({tag, "_eye"}, eye_width, 0);
    check({tag, "_lock"}, lock_fail, 0);
    check({tag, "_busy_done"}, {busy, done}, 0);
  endtask

  task automatic run_scan(input int m, input int off, input bit gap, input bit extra_start);
    prep(m, off, gap);
    pulse_start();
    check("busy_after_start", busy, 1);
    if (extra_start) begin
      repeat (500) @(negedge clk160);
      start = 1'b1;
      @(negedge clk160);
      start = 1'b0;
      check("busy_after_ignored_start", busy, 1);
    end
    for (int i = 0; i < 30000 && done_cnt == 0; i++) @(negedge clk160);
    check("done_seen", done_cnt > 0, 1);
    repeat (3) @(negedge clk160);
    check("done_pulses_once", done_cnt, 1);
    check("busy_cleared", busy, 0);
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("m%0d_ch%0d_strobes", m, c), strobe_cnt[c], npts + 1);
      check($sformatf("m%0d_ch%0d_eye_width", m, c), eye_width[c*TAP_W +: TAP_W], exp_width[c]);
      check($sformatf("m%0d_ch%0d_lock_fail", m, c), lock_fail[c], exp_lock[c]);
      check($sformatf("m%0d_ch%0d_final_p", m, c), delay_set_p[c*TAP_W +: TAP_W], exp_centre[c]);
      check($sformatf("m%0d_ch%0d_final_n", m, c), delay_set_n[c*TAP_W +: TAP_W], exp_centre[c]);
    end
  endtask

  initial begin
    int tot;
    #12;
    check_zero_outputs("reset");
    @(negedge clk160);
    rstb = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk160);
    check("idle_busy", busy, 0);

    run_scan(0, 0, 1'b0, 1'b0);    // ideal data on all links
    run_scan(1, 0, 1'b0, 1'b0);    // twin windows ch0, narrow ch1, dead ch2
    run_scan(0, 200, 1'b1, 1'b0);  // offset sweep with valid gaps inside each dwell

    // Abort mid-dwell on channel 1.
    prep(0, 0, 1'b0);
    pulse_start();
    for (int i = 0; i < 20000 && strobe_cnt[1] < 3; i++) @(negedge clk160);
    check("reached_ch1", strobe_cnt[1] >= 3, 1);
    repeat (SETTLE_CYC + 10) @(negedge clk160);
    #2 rstb = 1'b0;
    #1 check_zero_outputs("abort");
    tot = strobe_total();
    repeat (5) @(negedge clk160);
    rstb = 1'b1;
    repeat (60) @(negedge clk160);
    check("no_strobe_after_abort", strobe_total(), tot);
    check("abort_busy", busy, 0);

    run_scan(1, 0, 1'b0, 1'b1);    // fresh scan after reset, with a start while busy

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
